l2_mem_responder: RTL and testbench



---
 rtl/l2_resp_pkg.sv | 20 ++
 rtl/l2_mem_responder_if.sv | 51 +++++
 rtl/l2_resp_pipe.sv | 42 ++++
 rtl/l2_mem_responder.sv | 127 ++++++++++++
 tb/tb_l2_mem_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/l2_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_resp_pkg
// Brief    : Shared types and constants for the L2 memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package l2_resp_pkg;

  // Grant-stall FSM states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Response opcode values (only driven when the error feature is built)
  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/l2_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_mem_responder_if
// Brief    : L2 crossbar request/response channel between one arbitrated
//            master and the memory-side responder.
//            Macro L2_RESP_ERR_EN adds the data_r_opc_o response field.
// Revision : 1.0 - initial release
// ============================================================================
interface l2_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 16
) ();

  logic                  data_req_i;
  logic [ADDR_WIDTH-1:0] data_add_i;
  logic                  data_wen_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic [BE_WIDTH-1:0]   data_be_i;
  logic [ID_WIDTH-1:0]   data_ID_i;
  logic                  data_gnt_o;
  logic                  data_r_valid_o;
  logic [ID_WIDTH-1:0]   data_r_ID_o;
  logic [DATA_WIDTH-1:0] data_r_rdata_o;
`ifdef L2_RESP_ERR_EN
  logic                  data_r_opc_o;
`endif

`ifdef L2_RESP_ERR_EN
  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    input  data_gnt_o, data_r_valid_o, data_r_ID_o, data_r_rdata_o, data_r_opc_o
  );
  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    output data_gnt_o, data_r_valid_o, data_r_ID_o, data_r_rdata_o, data_r_opc_o
  );
`else
  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    input  data_gnt_o, data_r_valid_o, data_r_ID_o, data_r_rdata_o
  );
  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    output data_gnt_o, data_r_valid_o, data_r_ID_o, data_r_rdata_o
  );
`endif

endinterface
`default_nettype wire

// File: rtl/l2_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : l2_resp_pipe
// Brief    : RD_LATENCY-deep response shift register. Payload is forced to
//            zero in empty slots so the outputs read 0 whenever valid is low.
// Revision : 1.0 - initial release
// ============================================================================
module l2_resp_pipe #(
  parameter int RD_LATENCY = 1,
  parameter int WIDTH      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [RD_LATENCY-1:0] vld;
  logic [WIDTH-1:0]      dat [RD_LATENCY];

  // Shift one stage per cycle; reset drops every in-flight response
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[RD_LATENCY-1];
  assign out_data  = dat[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/l2_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : l2_mem_responder
// Brief    : Memory-side slave for one L2 crossbar channel. Grants requests
//            (optionally after WAIT_CYCLES stall cycles), performs the access
//            on a word-addressed array and returns one response per transfer
//            RD_LATENCY cycles later with the echoed ID.
//            Macro L2_RESP_ERR_EN: out-of-range addresses are flagged with
//            opc=1, writes to them are dropped and they return rdata=0.
// Revision : 1.0 - initial release
// ============================================================================
module l2_mem_responder
  import l2_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BE_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH    = 16,
  parameter int MEM_DEPTH   = 1024,
  parameter int RD_LATENCY  = 1,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  l2_mem_responder_if.slave  bus
);

  localparam int OFF_BITS = $clog2(BE_WIDTH);
  localparam int IDX_BITS = $clog2(MEM_DEPTH);
  localparam int CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
`ifdef L2_RESP_ERR_EN
  localparam int PAY_W    = ID_WIDTH + DATA_WIDTH + 1;
`else
  localparam int PAY_W    = ID_WIDTH + DATA_WIDTH;
`endif

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  gnt;
  logic                  hs;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IDX_BITS-1:0]   idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [PAY_W-1:0]      pay_in;
  logic [PAY_W-1:0]      pay_out;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte offset dropped; upper bits above the index alias unless checked
  assign word_addr = bus.data_add_i >> OFF_BITS;
  assign idx       = word_addr[IDX_BITS-1:0];

  // Grant is combinational from state and req, forced low during reset
  always_comb begin
    gnt = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    gnt = (WAIT_CYCLES == 0) ? bus.data_req_i : 1'b0;
        WAIT:    gnt = (cnt == '0) ? bus.data_req_i : 1'b0;
        default: gnt = 1'b0;
      endcase
    end
  end

  assign bus.data_gnt_o = gnt;
  assign hs             = bus.data_req_i & gnt;

  // Stall FSM: every new request waits WAIT_CYCLES cycles before its grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_req_i && (WAIT_CYCLES != 0)) begin
            state <= WAIT;
            cnt   <= CNT_W'(WAIT_CYCLES - 1);
          end
        end
        WAIT: begin
          if (!bus.data_req_i) state <= IDLE;
          else if (cnt != '0)  cnt   <= cnt - 1'b1;
          else                 state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L2_RESP_ERR_EN
  logic err;
  assign err     = (word_addr >> IDX_BITS) != '0;
  assign wr_en   = hs & ~bus.data_wen_i & ~err;
  assign rd_word = (bus.data_wen_i && !err) ? mem[idx] : '0;
  assign pay_in  = {bus.data_ID_i, rd_word, (err ? OPC_ERR : OPC_OK)};
  assign {bus.data_r_ID_o, bus.data_r_rdata_o, bus.data_r_opc_o} = pay_out;
`else
  assign wr_en   = hs & ~bus.data_wen_i;
  assign rd_word = bus.data_wen_i ? mem[idx] : '0;
  assign pay_in  = {bus.data_ID_i, rd_word};
  assign {bus.data_r_ID_o, bus.data_r_rdata_o} = pay_out;
`endif

  // Byte-masked write; array contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (bus.data_be_i[b]) mem[idx][b*8 +: 8] <= bus.data_wdata_i[b*8 +: 8];
      end
    end
  end

  l2_resp_pipe #(
    .RD_LATENCY (RD_LATENCY),
    .WIDTH      (PAY_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (hs),
    .in_data   (pay_in),
    .out_valid (bus.data_r_valid_o),
    .out_data  (pay_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_mem_responder
// Brief    : Scoreboard bench for l2_mem_responder. Three instances cover the
//            default build, WAIT_CYCLES=2 and RD_LATENCY=3.
//            Macro L2_RESP_ERR_EN enables the out-of-range error vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_mem_responder;
  import l2_resp_pkg::*;

  typedef struct {
    logic [15:0] id;
    logic [63:0] rdata;
    logic        opc;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_c = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_mem_responder_if ifa ();
  l2_mem_responder_if ifb ();
  l2_mem_responder_if ifc ();

  l2_mem_responder #(.RD_LATENCY(1), .WAIT_CYCLES(0)) dut_a (.clk(clk), .rst(rst),   .bus(ifa));
  l2_mem_responder #(.RD_LATENCY(1), .WAIT_CYCLES(2)) dut_b (.clk(clk), .rst(rst),   .bus(ifb));
  l2_mem_responder #(.RD_LATENCY(3), .WAIT_CYCLES(0)) dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

  logic opc_a, opc_b, opc_c;
`ifdef L2_RESP_ERR_EN
  assign opc_a = ifa.data_r_opc_o;
  assign opc_b = ifb.data_r_opc_o;
  assign opc_c = ifc.data_r_opc_o;
`else
  assign opc_a = 1'b0;
  assign opc_b = 1'b0;
  assign opc_c = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [15:0] id,
                     input logic [63:0] rd, input logic opc);
    chk({tag, "_id"}, 64'(id), 64'(e.id));
    chk({tag, "_rdata"}, rd, e.rdata);
    chk({tag, "_cycle"}, 64'(cyc), 64'(e.due));
`ifdef L2_RESP_ERR_EN
    chk({tag, "_opc"}, 64'(opc), 64'(e.opc));
`endif
  endtask

  task automatic unexpected(input string tag);
    checks++;
    errors++;
    $display("FAIL %s_unexpected_rvalid actual=1 required=0 (cycle %0d)", tag, cyc);
  endtask

  // Response monitors: pop and compare whenever a DUT presents r_valid
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.data_r_valid_o) begin
        if (qa.size() == 0) unexpected("a");
        else cmp("a", qa.pop_front(), ifa.data_r_ID_o, ifa.data_r_rdata_o, opc_a);
      end else begin
        chk("a_idle_rdata", ifa.data_r_rdata_o, 64'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ifb.data_r_valid_o) begin
      if (qb.size() == 0) unexpected("b");
      else cmp("b", qb.pop_front(), ifb.data_r_ID_o, ifb.data_r_rdata_o, opc_b);
    end
  end

  always @(negedge clk) begin
    if (!rst_c && ifc.data_r_valid_o) begin
      if (qc.size() == 0) unexpected("c");
      else cmp("c", qc.pop_front(), ifc.data_r_ID_o, ifc.data_r_rdata_o, opc_c);
    end
  end

  task automatic a_xfer(input logic wen, input logic [31:0] add, input logic [63:0] wd,
                        input logic [7:0] be, input logic [15:0] id,
                        input logic [63:0] exp_rd, input logic exp_opc);
    ifa.data_req_i = 1'b1; ifa.data_wen_i = wen; ifa.data_add_i = add;
    ifa.data_wdata_i = wd; ifa.data_be_i = be; ifa.data_ID_i = id;
    @(negedge clk);
    chk("a_gnt", 64'(ifa.data_gnt_o), 64'h1);
    qa.push_back('{id, exp_rd, exp_opc, cyc + 1});
    @(posedge clk); #1;
    ifa.data_req_i = 1'b0;
  endtask

  task automatic c_xfer(input logic wen, input logic [31:0] add, input logic [63:0] wd,
                        input logic [7:0] be, input logic [15:0] id, input logic [63:0] exp_rd);
    ifc.data_req_i = 1'b1; ifc.data_wen_i = wen; ifc.data_add_i = add;
    ifc.data_wdata_i = wd; ifc.data_be_i = be; ifc.data_ID_i = id;
    @(negedge clk);
    chk("c_gnt", 64'(ifc.data_gnt_o), 64'h1);
    qc.push_back('{id, exp_rd, OPC_OK, cyc + 3});
    @(posedge clk); #1;
    ifc.data_req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.data_req_i = 1'b1; ifa.data_add_i = '0; ifa.data_wen_i = 1'b1;
    ifa.data_wdata_i = '0; ifa.data_be_i = '0; ifa.data_ID_i = '0;
    ifb.data_req_i = 1'b0; ifb.data_add_i = '0; ifb.data_wen_i = 1'b0;
    ifb.data_wdata_i = '0; ifb.data_be_i = '0; ifb.data_ID_i = '0;
    ifc.data_req_i = 1'b0; ifc.data_add_i = '0; ifc.data_wen_i = 1'b1;
    ifc.data_wdata_i = '0; ifc.data_be_i = '0; ifc.data_ID_i = '0;

    // Reset state, with a request pending on instance A
    @(posedge clk); @(negedge clk);
    chk("rst_gnt", 64'(ifa.data_gnt_o), 64'h0);
    chk("rst_rvalid", 64'(ifa.data_r_valid_o), 64'h0);
    chk("rst_rid", 64'(ifa.data_r_ID_o), 64'h0);
    chk("rst_rdata", ifa.data_r_rdata_o, 64'h0);
    @(posedge clk); #1;
    ifa.data_req_i = 1'b0; rst = 1'b0; rst_c = 1'b0;

    // Instance A: full write, read back, partial write, aliasing / error
    a_xfer(1'b0, 32'h0,  64'hA5A5_0000_5A5A_FFFF, 8'hFF, 16'h0001, 64'h0, OPC_OK);
    a_xfer(1'b0, 32'h10, 64'h1122_3344_5566_7788, 8'hFF, 16'h0004, 64'h0, OPC_OK);
    a_xfer(1'b1, 32'h10, 64'h0, 8'h00, 16'h0008, 64'h1122_3344_5566_7788, OPC_OK);
    a_xfer(1'b0, 32'h10, 64'h0, 8'h0F, 16'h0002, 64'h0, OPC_OK);
    a_xfer(1'b1, 32'h10, 64'h0, 8'h00, 16'h0010, 64'h1122_3344_0000_0000, OPC_OK);
`ifdef L2_RESP_ERR_EN
    a_xfer(1'b0, 32'h2000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 16'h0020, 64'h0, OPC_ERR);
    a_xfer(1'b1, 32'h0,    64'h0, 8'h00, 16'h0040, 64'hA5A5_0000_5A5A_FFFF, OPC_OK);
    a_xfer(1'b1, 32'h2010, 64'h0, 8'h00, 16'h0080, 64'h0, OPC_ERR);
`else
    a_xfer(1'b0, 32'h2000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 16'h0020, 64'h0, OPC_OK);
    a_xfer(1'b1, 32'h0,    64'h0, 8'h00, 16'h0040, 64'hDEAD_BEEF_CAFE_F00D, OPC_OK);
    a_xfer(1'b1, 32'h2010, 64'h0, 8'h00, 16'h0080, 64'h1122_3344_0000_0000, OPC_OK);
`endif
    repeat (3) @(posedge clk);
    #1;

    // Instance B: request held; grants expected in relative cycles 2 and 5
    ifb.data_ID_i = 16'h0010; ifb.data_req_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("b_gnt", 64'(ifb.data_gnt_o), ((k == 2) || (k == 5)) ? 64'h1 : 64'h0);
      if (k == 2) qb.push_back('{16'h0010, 64'h0, OPC_OK, cyc + 1});
      if (k == 5) qb.push_back('{16'h0020, 64'h0, OPC_OK, cyc + 1});
      @(posedge clk); #1;
      if (k == 2) ifb.data_ID_i = 16'h0020;
    end
    ifb.data_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Instance C: fill four words, then four back-to-back reads
    for (int i = 0; i < 4; i++)
      c_xfer(1'b0, 32'(i * 8), 64'(i + 1), 8'hFF, 16'h0100, 64'h0);
    for (int i = 0; i < 4; i++)
      c_xfer(1'b1, 32'(i * 8), 64'h0, 8'h00, 16'(1 << i), 64'(i + 1));
    repeat (5) @(posedge clk);
    #1;

    // Instance C: reset one cycle after a grant must drop the response
    ifc.data_req_i = 1'b1; ifc.data_wen_i = 1'b1; ifc.data_add_i = 32'h8; ifc.data_ID_i = 16'h0040;
    @(negedge clk);
    chk("c_gnt_pre_rst", 64'(ifc.data_gnt_o), 64'h1);
    @(posedge clk); #1;
    ifc.data_req_i = 1'b0; rst_c = 1'b1;
    @(posedge clk); #1;
    rst_c = 1'b0;
    @(negedge clk);
    chk("c_post_rst_rvalid", 64'(ifc.data_r_valid_o), 64'h0);
    chk("c_post_rst_rid", 64'(ifc.data_r_ID_o), 64'h0);
    chk("c_post_rst_rdata", ifc.data_r_rdata_o, 64'h0);
    chk("c_post_rst_fsm", 64'(dut_c.state), 64'(IDLE));
    repeat (5) @(posedge clk);
    #1;

    chk("a_queue_empty", 64'(qa.size()), 64'h0);
    chk("b_queue_empty", 64'(qb.size()), 64'h0);
    chk("c_queue_empty", 64'(qc.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
